// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit datapath: widths, fetch FSM states and
// the opcode fields that fetch and decode both need to agree on.
package cpu_pkg;

   localparam int CPU_ADDR_W = 16;
   localparam int INSTR_W    = 16;

   typedef enum logic {
      FETCH   = 1'b0,
      DISCARD = 1'b1
   } fetch_state_t;

   localparam logic [3:0] OP_LOADSTORE = 4'b0100;
   localparam logic [3:0] OP_BCOND     = 4'b1100;

   localparam logic [3:0] EXT_LOAD  = 4'b0000;
   localparam logic [3:0] EXT_STOR  = 4'b0100;
   localparam logic [3:0] EXT_JCOND = 4'b1100;
   localparam logic [3:0] EXT_JAL   = 4'b1000;

   function automatic logic [3:0] instr_opcode(input logic [INSTR_W-1:0] instr);
      return instr[15:12];
   endfunction

   function automatic logic [3:0] instr_ext(input logic [INSTR_W-1:0] instr);
      return instr[7:4];
   endfunction

   // Anything that can make execute raise a redirect back into fetch
   function automatic logic is_control_flow(input logic [INSTR_W-1:0] instr);
      logic [3:0] op;
      logic [3:0] ext;
      op  = instr_opcode(instr);
      ext = instr_ext(instr);
      return (op == OP_BCOND) ||
             ((op == OP_LOADSTORE) && ((ext == EXT_JCOND) || (ext == EXT_JAL)));
   endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Small synchronous FIFO holding fetched {instr, pc} entries. Flush overrides
// push and pop; the head is kept in a register so it holds when the FIFO drains.
module fetch_buffer #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 32
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    push,
   input  logic                    pop,
   input  logic                    flush,
   input  logic [WIDTH-1:0]        wdata,
   output logic [WIDTH-1:0]        rdata,
   output logic                    full,
   output logic                    empty,
   output logic [$clog2(DEPTH):0]  count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr_nxt;
   logic [CNT_W-1:0] remain;
   logic [CNT_W-1:0] count_nxt;
   logic             do_push;
   logic             do_pop;
   logic [WIDTH-1:0] head_nxt;

   assign full  = (count == CNT_W'(DEPTH));
   assign empty = (count == '0);

   // When the pop leaves nothing behind, the incoming word becomes the head
   always_comb begin
      do_pop     = pop && !empty;
      do_push    = push && (!full || do_pop);
      remain     = count - CNT_W'(do_pop);
      count_nxt  = remain + CNT_W'(do_push);
      rd_ptr_nxt = rd_ptr + PTR_W'(do_pop);
      head_nxt   = (remain == '0) ? wdata : mem[rd_ptr_nxt];
   end

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         rd_ptr <= rd_ptr_nxt;
         count  <= count_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush && !reset) begin
         mem[wr_ptr] <= wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rdata <= '0;
      end else if (!flush && (count_nxt != '0)) begin
         rdata <= head_nxt;
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues single outstanding word reads
// and hands buffered instructions with their PC to decode.
module fetch_unit
   import cpu_pkg::*;
#(
   parameter int                ADDR_W    = CPU_ADDR_W,
   parameter logic [ADDR_W-1:0] RESET_PC  = '0,
   parameter int                BUF_DEPTH = 2
) (
   input  logic               clk,
   input  logic               reset,
   output logic               mem_req,
   output logic [ADDR_W-1:0]  mem_addr,
   input  logic               mem_ack,
   input  logic [INSTR_W-1:0] mem_rdata,
   input  logic               redirect_valid,
   input  logic [ADDR_W-1:0]  redirect_pc,
   output logic               instr_valid,
   input  logic               instr_ready,
   output logic [INSTR_W-1:0] instr_out,
   output logic [ADDR_W-1:0]  instr_pc
);

   localparam int CNT_W   = $clog2(BUF_DEPTH) + 1;
   localparam int ENTRY_W = INSTR_W + ADDR_W;

   fetch_state_t      state;
   fetch_state_t      state_nxt;
   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] stale_addr;
   logic              fetch_done;
   logic              buf_push;
   logic              buf_pop;
   logic              buf_full;
   logic              buf_empty;
   logic [CNT_W-1:0]  buf_count;
   logic [ENTRY_W-1:0] buf_rdata;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= FETCH;
      end else begin
         state <= state_nxt;
      end
   end

   // A redirect while a read is in flight must wait out that read before refetching
   always_comb begin
      state_nxt = state;
      case (state)
         FETCH: begin
            if (redirect_valid && mem_req && !mem_ack) begin
               state_nxt = DISCARD;
            end
         end
         DISCARD: begin
            if (mem_ack) begin
               state_nxt = FETCH;
            end
         end
         default: state_nxt = FETCH;
      endcase
   end

   // Request only with a free slot as of this cycle, so a push never overflows
   always_comb begin
      mem_req  = 1'b0;
      mem_addr = (state == DISCARD) ? stale_addr : pc;
      if (!reset) begin
         case (state)
            FETCH:   mem_req = (buf_count < CNT_W'(BUF_DEPTH));
            DISCARD: mem_req = 1'b1;
            default: mem_req = 1'b0;
         endcase
      end
   end

   assign fetch_done = mem_req && mem_ack && (state == FETCH);
   assign buf_pop    = instr_valid && instr_ready && !redirect_valid;
   assign buf_push   = fetch_done && !redirect_valid && (!buf_full || buf_pop);

   always_ff @(posedge clk) begin
      if (reset) begin
         pc         <= RESET_PC;
         stale_addr <= RESET_PC;
      end else begin
         if (redirect_valid) begin
            pc <= redirect_pc;
         end else if (buf_push) begin
            pc <= pc + ADDR_W'(1);
         end
         if ((state == FETCH) && (state_nxt == DISCARD)) begin
            stale_addr <= pc;
         end
      end
   end

   fetch_buffer #(
      .DEPTH (BUF_DEPTH),
      .WIDTH (ENTRY_W)
   ) u_buffer (
      .clk   (clk),
      .reset (reset),
      .push  (buf_push),
      .pop   (buf_pop),
      .flush (redirect_valid),
      .wdata ({mem_rdata, pc}),
      .rdata (buf_rdata),
      .full  (buf_full),
      .empty (buf_empty),
      .count (buf_count)
   );

   assign instr_valid = !buf_empty;
   assign instr_out   = buf_rdata[ENTRY_W-1:ADDR_W];
   assign instr_pc    = buf_rdata[ADDR_W-1:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed and randomized bench for fetch_unit. A memory model answers reads
// with addr^A5A5 and a stream model expects contiguous PCs from each restart point.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        mem_req;
   logic [15:0] mem_addr;
   logic        mem_ack;
   logic [15:0] mem_rdata;
   logic        redirect_valid;
   logic [15:0] redirect_pc;
   logic        instr_valid;
   logic        instr_ready;
   logic [15:0] instr_out;
   logic [15:0] instr_pc;

   int errors = 0;
   int checks = 0;

   int latency  = 0;
   int wait_cnt = 0;
   bit rand_lat = 0;

   logic [15:0] exp_pc = 16'h0000;
   int          accepts = 0;

   logic        s_req;
   logic [15:0] s_addr;
   logic        s_ack;
   logic        s_valid;
   logic [15:0] s_pc;
   logic [15:0] s_out;

   always #5 clk = ~clk;

   fetch_unit dut (
      .clk            (clk),
      .reset          (reset),
      .mem_req        (mem_req),
      .mem_addr       (mem_addr),
      .mem_ack        (mem_ack),
      .mem_rdata      (mem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .instr_out      (instr_out),
      .instr_pc       (instr_pc)
   );

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // One clock cycle: drive inputs, answer memory, run the stream model, advance.
   task automatic applyStimulus(input logic rst, input logic redir, input logic [15:0] rpc, input logic ready);
      reset          = rst;
      redirect_valid = redir;
      redirect_pc    = rpc;
      instr_ready    = ready;
      mem_ack        = 1'b0;
      #1;
      s_req  = mem_req;
      s_addr = mem_addr;
      s_ack  = (s_req === 1'b1) && (wait_cnt >= latency);
      mem_ack   = s_ack;
      mem_rdata = s_ack ? (s_addr ^ 16'hA5A5) : 16'($urandom);
      #1;
      s_valid = instr_valid;
      s_pc    = instr_pc;
      s_out   = instr_out;
      if (rst) begin
         exp_pc = 16'h0000;
      end else if (redir) begin
         exp_pc = rpc;
      end else if ((s_valid === 1'b1) && ready) begin
         checkOutput("stream_pc", s_pc, exp_pc);
         checkOutput("stream_instr", s_out, exp_pc ^ 16'hA5A5);
         exp_pc = exp_pc + 16'd1;
         accepts++;
      end
      if (s_ack) begin
         wait_cnt = 0;
         if (rand_lat) latency = $urandom_range(0, 3);
      end else if (s_req === 1'b1) begin
         wait_cnt++;
      end else begin
         wait_cnt = 0;
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      int          fetched;
      bit          found;
      bit          prev_pending;
      logic [15:0] prev_addr;
      int          acc_start;

      // Reset values
      applyStimulus(1'b1, 1'b0, 16'h0, 1'b1);
      applyStimulus(1'b1, 1'b0, 16'h0, 1'b1);
      checkOutput("rst_mem_req", s_req, 1'b0);
      checkOutput("rst_mem_addr", s_addr, 16'h0000);
      checkOutput("rst_instr_valid", s_valid, 1'b0);
      checkOutput("rst_instr_out", s_out, 16'h0000);
      checkOutput("rst_instr_pc", s_pc, 16'h0000);

      // Zero-wait memory, decode always ready
      latency = 0;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b0, 1'b0, 16'h0, 1'b1);
         checkOutput("zw_req", s_req, 1'b1);
         checkOutput("zw_addr", s_addr, 16'(i));
         checkOutput("zw_valid", s_valid, (i != 0));
         if (i > 0) begin
            checkOutput("zw_pc", s_pc, 16'(i - 1));
            checkOutput("zw_instr", s_out, 16'(i - 1) ^ 16'hA5A5);
         end
      end

      // Decode stalls: buffer fills to depth, then requests stop
      applyStimulus(1'b1, 1'b0, 16'h0, 1'b0);
      fetched = 0;
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1'b0, 1'b0, 16'h0, 1'b0);
         if (s_req && s_ack) fetched++;
      end
      checkOutput("stall_fetched", fetched, 2);
      checkOutput("stall_req", s_req, 1'b0);
      checkOutput("stall_head_pc", s_pc, 16'h0000);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 1'b0, 16'h0, 1'b1);
         checkOutput("release_valid", s_valid, 1'b1);
         checkOutput("release_pc", s_pc, 16'(i));
      end

      // Redirect while a 3-cycle read is pending
      latency = 3;
      applyStimulus(1'b1, 1'b0, 16'h0, 1'b1);
      applyStimulus(1'b0, 1'b0, 16'h0, 1'b1);
      applyStimulus(1'b0, 1'b1, 16'h0040, 1'b1);
      checkOutput("redir_pending", s_req && !s_ack, 1'b1);
      applyStimulus(1'b0, 1'b0, 16'h0, 1'b1);
      checkOutput("discard_req", s_req, 1'b1);
      checkOutput("discard_addr", s_addr, 16'h0000);
      checkOutput("discard_valid", s_valid, 1'b0);
      applyStimulus(1'b0, 1'b0, 16'h0, 1'b1);
      checkOutput("discard_ack", s_ack, 1'b1);
      checkOutput("discard_ack_addr", s_addr, 16'h0000);
      applyStimulus(1'b0, 1'b0, 16'h0, 1'b1);
      checkOutput("refetch_addr", s_addr, 16'h0040);
      checkOutput("stale_dropped", s_valid, 1'b0);
      found = 0;
      for (int i = 0; i < 20; i++) begin
         applyStimulus(1'b0, 1'b0, 16'h0, 1'b1);
         if (s_valid === 1'b1) begin
            found = 1;
            break;
         end
      end
      checkOutput("redir_first_valid", found, 1'b1);
      checkOutput("redir_first_pc", s_pc, 16'h0040);

      // Redirect in the same cycle as an ack and a pop
      latency = 0;
      applyStimulus(1'b1, 1'b0, 16'h0, 1'b1);
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 16'h0, 1'b1);
      applyStimulus(1'b0, 1'b1, 16'h0100, 1'b1);
      checkOutput("redir_ack_setup", s_req && s_ack && s_valid, 1'b1);
      applyStimulus(1'b0, 1'b0, 16'h0, 1'b1);
      checkOutput("redir_ack_empty", s_valid, 1'b0);
      checkOutput("redir_ack_addr", s_addr, 16'h0100);
      applyStimulus(1'b0, 1'b0, 16'h0, 1'b1);
      checkOutput("redir_ack_pc", s_pc, 16'h0100);

      // PC wrap
      applyStimulus(1'b0, 1'b1, 16'hFFFF, 1'b1);
      applyStimulus(1'b0, 1'b0, 16'h0, 1'b1);
      checkOutput("wrap_addr0", s_addr, 16'hFFFF);
      applyStimulus(1'b0, 1'b0, 16'h0, 1'b1);
      checkOutput("wrap_addr1", s_addr, 16'h0000);
      checkOutput("wrap_pc0", s_pc, 16'hFFFF);
      applyStimulus(1'b0, 1'b0, 16'h0, 1'b1);
      checkOutput("wrap_pc1", s_pc, 16'h0000);

      // Reset while a read is pending with data buffered
      latency = 3;
      applyStimulus(1'b1, 1'b0, 16'h0, 1'b0);
      for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 16'h0, 1'b0);
      checkOutput("rstmid_setup", s_req && s_valid, 1'b1);
      applyStimulus(1'b1, 1'b0, 16'h0, 1'b0);
      checkOutput("rstmid_req_drop", s_req, 1'b0);
      applyStimulus(1'b1, 1'b0, 16'h0, 1'b0);
      checkOutput("rstmid_req", s_req, 1'b0);
      checkOutput("rstmid_valid", s_valid, 1'b0);
      applyStimulus(1'b0, 1'b0, 16'h0, 1'b0);
      checkOutput("rstmid_restart_req", s_req, 1'b1);
      checkOutput("rstmid_restart_addr", s_addr, 16'h0000);

      // Randomized traffic against the stream model
      applyStimulus(1'b1, 1'b0, 16'h0, 1'b1);
      rand_lat     = 1;
      prev_pending = 0;
      prev_addr    = 16'h0;
      for (int i = 0; i < 400; i++) begin
         applyStimulus(1'b0, ($urandom_range(0, 19) == 0), 16'($urandom),
                       ($urandom_range(0, 3) != 0));
         if (prev_pending) begin
            checkOutput("rand_req_held", s_req, 1'b1);
            checkOutput("rand_addr_stable", s_addr, prev_addr);
         end
         prev_pending = s_req && !s_ack;
         prev_addr    = s_addr;
      end

      // Sustained throughput with zero-wait memory
      rand_lat = 0;
      latency  = 0;
      for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 16'h0, 1'b1);
      acc_start = accepts;
      for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 16'h0, 1'b1);
      checkOutput("throughput", accepts - acc_start, 10);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
